// File: rtl/div_sched.sv
// Round-robin front end for a shared two-stage fixed-point divider: arbitrates
// requesters, aligns operands to the divider stages, and routes saturated results back.
module div_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned A_W   = 9,
  parameter int unsigned B_W   = 9,
  parameter int unsigned O_I_W = 4,
  parameter int unsigned O_F_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*A_W-1:0]     req_a,
  input  logic [N_REQ*B_W-1:0]     req_b,
  output logic [A_W-1:0]           div_a,
  output logic [B_W-1:0]           div_b,
  input  logic [O_I_W+O_F_W-1:0]   div_o,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [O_I_W+O_F_W-1:0]   rsp_o,
  output logic                     rsp_sat,
  output logic                     rsp_dz
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CMP_W = ((A_W > B_W) ? A_W : B_W) + O_I_W + 1;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic             dz;
    logic             ovf;
  } tag_t;

  logic [IDX_W:0]   w_sh;
  logic [IDX_W:0]   w_sum;
  logic [N_REQ-1:0] w_rot;
  logic             w_any;
  logic             w_acc;
  logic [IDX_W-1:0] w_idx;
  logic [A_W-1:0]   w_a;
  logic [B_W-1:0]   w_b;
  logic             w_dz;
  logic             w_ovf;

  logic [IDX_W-1:0] r_ptr;
  logic [B_W-1:0]   r_b1;
  tag_t             r_tag1;
  tag_t             r_tag2;
  tag_t             r_tag3;

  // Rotate valids so bit 0 is the pointer position; lowest set bit wins.
  always_comb begin
    w_sh  = (IDX_W+1)'(N_REQ) - (IDX_W+1)'(r_ptr);
    w_rot = (req_valid >> r_ptr) | (req_valid << w_sh);
    w_any = 1'b0;
    w_idx = '0;
    w_sum = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_any = 1'b1;
        w_sum = (IDX_W+1)'(r_ptr) + (IDX_W+1)'(k);
        w_idx = (w_sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(N_REQ))
                                             : IDX_W'(w_sum);
      end
    end
  end

  assign w_acc     = w_any & ~rst;
  assign req_ready = w_acc ? (N_REQ'(1) << w_idx) : '0;

  // Operand select and exception classification for the granted request.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_idx == IDX_W'(k)) begin
        w_a = req_a[k*A_W +: A_W];
        w_b = req_b[k*B_W +: B_W];
      end
    end
    w_dz  = (w_b == '0);
    w_ovf = !w_dz && (CMP_W'(w_a) >= (CMP_W'(w_b) << O_I_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_b1      <= '0;
      r_tag1    <= '0;
      r_tag2    <= '0;
      r_tag3    <= '0;
      div_a     <= '0;
      div_b     <= '0;
      rsp_valid <= '0;
      rsp_o     <= '0;
      rsp_sat   <= 1'b0;
      rsp_dz    <= 1'b0;
    end else begin
      if (w_acc) begin
        div_a <= w_a;
        r_b1  <= w_dz ? B_W'(1) : w_b;
        r_ptr <= (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
      end
      // Divisor lags the dividend by one edge to match the divider's input staging.
      if (r_tag1.vld) begin
        div_b <= r_b1;
      end
      r_tag1.vld <= w_acc;
      r_tag1.idx <= w_idx;
      r_tag1.dz  <= w_dz;
      r_tag1.ovf <= w_ovf;
      r_tag2     <= r_tag1;
      r_tag3     <= r_tag2;
      if (r_tag3.vld) begin
        rsp_valid <= N_REQ'(1) << r_tag3.idx;
        rsp_o     <= (r_tag3.dz | r_tag3.ovf) ? '1 : div_o;
        rsp_sat   <= r_tag3.dz | r_tag3.ovf;
        rsp_dz    <= r_tag3.dz;
      end else begin
        rsp_valid <= '0;
        rsp_o     <= '0;
        rsp_sat   <= 1'b0;
        rsp_dz    <= 1'b0;
      end
    end
  end

endmodule
